// File: rtl/eeprom_req_arbiter.sv
// Round-robin arbiter in front of a single-byte EEPROM command port.
// Accepts one request at a time, issues a one-cycle read or write command,
// waits for the controller's done pulse (or times out), returns a one-cycle
// response, and after every write holds off new requests for the tWR window.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer; grants the next requester round-robin
// ISSUE  | granted request latched; command pulse emitted next cycle
// WAIT   | command outstanding; waits for ee_done or timeout
// WRWAIT | write finished; EEPROM internal write cycle in progress

module eeprom_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 16,
    parameter int BW      = 8,
    parameter int TWR_CYC = 500000,
    parameter int TO_CYC  = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*BW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [BW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [AW-1:0]     ee_addr,
    output logic [BW-1:0]     ee_wdata,
    output logic              ee_wcmd,
    output logic              ee_rcmd,
    input  logic [BW-1:0]     ee_rdata,
    input  logic              ee_done
);

    localparam int GW  = (NREQ > 1)    ? $clog2(NREQ)    : 1;
    localparam int TOW = (TO_CYC > 1)  ? $clog2(TO_CYC)  : 1;
    localparam int TWW = (TWR_CYC > 1) ? $clog2(TWR_CYC) : 1;

    localparam logic [TOW-1:0] TO_LAST  = TOW'(TO_CYC - 1);
    localparam logic [TWW-1:0] TWR_LOAD = TWW'(TWR_CYC - 1);
    localparam logic [GW-1:0]  LAST_RST = GW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        WRWAIT = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic            we_q;
    logic [TOW-1:0]  to_cnt;
    logic [TWW-1:0]  twr_cnt;

    logic            grant_found;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   cand;

    // Round-robin pick: first pending requester after the last one granted.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Sequencer with registered handshake, command and response outputs.
    // The timeout counter counts up from the command cycle; the tWR hold-off
    // counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= LAST_RST;
            we_q       <= 1'b0;
            to_cnt     <= '0;
            twr_cnt    <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            ee_addr    <= '0;
            ee_wdata   <= '0;
            ee_wcmd    <= 1'b0;
            ee_rcmd    <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ee_wcmd   <= 1'b0;
            ee_rcmd   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        req_ready  <= NREQ'(1) << grant_idx;
                        last_grant <= grant_idx;
                        we_q       <= req_we[grant_idx];
                        ee_addr    <= req_addr[grant_idx*AW +: AW];
                        ee_wdata   <= req_wdata[grant_idx*BW +: BW];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ee_wcmd <= we_q;
                    ee_rcmd <= ~we_q;
                    to_cnt  <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    // done takes precedence over a coincident timeout
                    if (ee_done || (to_cnt == TO_LAST)) begin
                        rsp_valid <= NREQ'(1) << last_grant;
                        rsp_err   <= ~ee_done;
                        rsp_rdata <= (ee_done && !we_q) ? ee_rdata : '0;
                        twr_cnt   <= TWR_LOAD;
                        state     <= we_q ? WRWAIT : IDLE;
                    end
                end
                WRWAIT: begin
                    if (twr_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        twr_cnt <= twr_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// Bench for eeprom_req_arbiter: directed scenarios followed by random rounds,
// checked against a transaction-level model (round-robin order, fixed
// accept/issue/response latencies, timeout and write-recovery windows).

module tb_eeprom_req_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int BW   = 8;
    localparam int TWR  = 20;
    localparam int TO   = 50;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*BW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [BW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               busy;
    logic [AW-1:0]      ee_addr;
    logic [BW-1:0]      ee_wdata;
    logic               ee_wcmd;
    logic               ee_rcmd;
    logic [BW-1:0]      ee_rdata;
    logic               ee_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eeprom_req_arbiter #(
        .NREQ(NREQ), .AW(AW), .BW(BW), .TWR_CYC(TWR), .TO_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .ee_addr(ee_addr), .ee_wdata(ee_wdata), .ee_wcmd(ee_wcmd), .ee_rcmd(ee_rcmd),
        .ee_rdata(ee_rdata), .ee_done(ee_done)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return (a == 16'h1234) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction

    // EEPROM device model: done pulse ee_n cycles after each command.
    logic [7:0]  dev_mem [logic [15:0]];
    int          ee_n = 10;
    int          ee_cnt;
    logic [15:0] ee_lat;

    always @(negedge clk) begin
        if (rst) begin
            ee_cnt   = 0;
            ee_done  = 1'b0;
            ee_rdata = 8'h00;
            ee_lat   = 16'h0000;
        end else begin
            ee_done = 1'b0;
            if (ee_cnt > 0) begin
                ee_cnt = ee_cnt - 1;
                if (ee_cnt == 0) begin
                    ee_done  = 1'b1;
                    ee_rdata = dev_mem.exists(ee_lat) ? dev_mem[ee_lat] : init_val(ee_lat);
                end
            end
            if (ee_rcmd || ee_wcmd) begin
                ee_cnt = ee_n;
                ee_lat = ee_addr;
                if (ee_wcmd) dev_mem[ee_addr] = ee_wdata;
            end
        end
    end

    // Reference state
    logic [7:0]  ref_mem [logic [15:0]];
    logic        we_a   [NREQ];
    logic [15:0] addr_a [NREQ];
    logic [7:0]  wd_a   [NREQ];
    int          n_a    [NREQ];
    int          last_g;

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] pend, input int last);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (((pend >> idx) & NREQ'(1)) != '0) return idx;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic post(input int i, input logic we, input logic [15:0] a, input logic [7:0] d,
                        input int n);
        we_a[i]   = we;
        addr_a[i] = a;
        wd_a[i]   = d;
        n_a[i]    = n;
        if (we) req_we = req_we | (NREQ'(1) << i);
        else    req_we = req_we & ~(NREQ'(1) << i);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*BW +: BW] = d;
        req_valid = req_valid | (NREQ'(1) << i);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, ee_addr, ee_wdata, ee_wcmd, ee_rcmd},
            64'd0);
    endtask

    // One full transaction for requester g, entered in a cycle where the DUT is idle.
    task automatic expect_txn(input int g);
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
        int          n;
        int          lat;
        logic        err;
        logic [7:0]  exp_rd;
        logic        bad;
        we = we_a[g];
        a  = addr_a[g];
        d  = wd_a[g];
        n  = n_a[g];
        ee_n = n;
        chk("busy_idle", busy, 0);
        tick();
        chk("req_ready", req_ready, 64'(1) << g);
        req_valid = req_valid & ~(NREQ'(1) << g);
        tick();
        chk("cmd", {ee_wcmd, ee_rcmd}, we ? 2'b10 : 2'b01);
        chk("ee_addr", ee_addr, a);
        if (we) chk("ee_wdata", ee_wdata, d);
        err = (n >= TO);
        lat = err ? TO : n + 1;
        if (we) ref_mem[a] = d;
        exp_rd = (we || err) ? 8'h00 : ref_rd(a);
        bad = 1'b0;
        for (int k = 1; k < lat; k++) begin
            tick();
            if (rsp_valid !== '0 || ee_addr !== a || ee_wcmd !== 1'b0 || ee_rcmd !== 1'b0 ||
                req_ready !== '0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("wait_window", bad, 0);
        tick();
        chk("rsp_valid", rsp_valid, 64'(1) << g);
        chk("rsp_err", rsp_err, err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        if (we) begin
            bad = 1'b0;
            for (int k = 1; k < TWR; k++) begin
                tick();
                if (busy !== 1'b1 || req_ready !== '0 || rsp_valid !== '0) bad = 1'b1;
            end
            chk("wrwait_window", bad, 0);
            tick();
        end
        chk("busy_after", busy, 0);
        chk("ready_quiet", req_ready, 0);
        last_g = g;
    endtask

    task automatic serve_all();
        for (int s = 0; s < NREQ; s++) begin
            if (req_valid != '0) expect_txn(rr_pick(req_valid, last_g));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_reset_outs("reset_outputs");
        rst = 1'b0;
        last_g = NREQ - 1;
    endtask

    initial begin
        int g;
        logic bad;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        last_g    = NREQ - 1;
        do_reset();
        tick();

        // read 0x1234, done after 10 cycles
        post(0, 1'b0, 16'h1234, 8'h00, 10);
        expect_txn(rr_pick(req_valid, last_g));

        // write from req1 while req0 read waits through the write recovery
        post(1, 1'b1, 16'h0010, 8'h5A, 10);
        post(0, 1'b0, 16'h0010, 8'h00, 7);
        serve_all();

        // both requesters hold valid for six reads
        do_reset();
        post(0, 1'b0, 16'h0012, 8'h00, 3);
        post(1, 1'b0, 16'h1234, 8'h00, 5);
        for (int j = 0; j < 6; j++) begin
            g = rr_pick(req_valid, last_g);
            expect_txn(g);
            if (j < 4) post(g, 1'b0, 16'(16'h0010 + $urandom_range(0, 7)), 8'h00,
                            int'($urandom_range(1, 20)));
        end

        // timeouts: read and write with no done
        post(0, 1'b0, 16'h0013, 8'h00, 1000);
        expect_txn(rr_pick(req_valid, last_g));
        post(1, 1'b1, 16'h0014, 8'hC3, 1000);
        expect_txn(rr_pick(req_valid, last_g));

        // done on the timeout cycle wins
        post(1, 1'b0, 16'h1234, 8'h00, TO - 1);
        expect_txn(rr_pick(req_valid, last_g));

        // reset during WAIT
        post(0, 1'b0, 16'h0011, 8'h00, 30);
        ee_n = 30;
        tick();
        chk("abort_ready", req_ready, 1);
        req_valid = '0;
        tick();
        chk("abort_cmd", ee_rcmd, 1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_reset_outs("async_reset");
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rsp_valid !== '0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("abort_no_rsp", bad, 0);
        rst = 1'b0;
        last_g = NREQ - 1;
        post(1, 1'b0, 16'h0015, 8'h00, 4);
        post(0, 1'b0, 16'h0016, 8'h00, 6);
        g = rr_pick(req_valid, last_g);
        chk("post_reset_pick", g, 0);
        serve_all();

        // random rounds
        for (int r = 0; r < 12; r++) begin
            logic [NREQ-1:0] mask;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if (((mask >> i) & NREQ'(1)) != '0)
                    post(i, 1'(($urandom_range(0, 1))), 16'(16'h0010 + $urandom_range(0, 7)),
                         8'($urandom), int'($urandom_range(1, 60)));
            end
            serve_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
